// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Optional feature macro: FIFO_ARB_SRC_ID_EN (see fifo_wr_arbiter.sv).
package fifo_arb_pkg;

   localparam int unsigned MAX_REQ = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Ceiling log2, never less than 1 so a 2-requester build still has an ID bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / shared-FIFO bundle for fifo_wr_arbiter.
// slave = arbiter view, master = environment (requesters + FIFO status).
// FIFO_ARB_SRC_ID_EN widens fifo_wr_data by the grant ID width.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned IDW = clog2_min1(NUM_REQ);
`ifdef FIFO_ARB_SRC_ID_EN
   localparam int unsigned FWW = DATA_WIDTH + IDW;
`else
   localparam int unsigned FWW = DATA_WIDTH;
`endif

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [FWW-1:0]                fifo_wr_data;
   logic                          fifo_full;
   logic                          fifo_almost_full;
   logic [IDW-1:0]                grant_id;
   logic                          busy;

   modport slave (
      input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start,
// wrapping past N-1 back to 0.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [N-1:0] rot;

   // Rotate so bit 0 is the start position, then take the lowest set bit.
   always_comb begin
      found = 1'b0;
      index = '0;
      rot   = N'({req, req} >> start);
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            index = IW'((32'(start) + i) % N);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter writing NUM_REQ requesters into one FIFO.
// A grant is held for a whole packet (until an accepted last beat).
// Macro FIFO_ARB_SRC_ID_EN: prefix fifo_wr_data with the owner's grant_id.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   fifo_wr_arbiter_if.slave   bus
);

   localparam int unsigned IDW = clog2_min1(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("fifo_wr_arbiter: NUM_REQ out of range 2..16");
   end

   arb_state_t             state;
   logic                   busy_q;
   logic [IDW-1:0]         grant_q;
   logic [IDW-1:0]         rr_ptr;

   logic                   pick_found;
   logic [IDW-1:0]         pick_idx;

   logic                   own_valid;
   logic                   own_last;
   logic [DATA_WIDTH-1:0]  own_data;
   logic [NUM_REQ-1:0]     ready_c;
   logic                   accept;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IDW)
   ) u_pick (
      .req   (bus.req_valid),
      .start (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   // Select the owner's signals and steer ready to the owner only.
   // Outputs are forced quiet during the reset cycle itself.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      ready_c   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q == IDW'(i)) begin
            own_valid  = bus.req_valid[i];
            own_last   = bus.req_last[i];
            own_data   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            ready_c[i] = (state == GRANT) && !rst && !bus.fifo_full;
         end
      end
   end

   assign accept         = (state == GRANT) && !rst && own_valid && !bus.fifo_full;
   assign bus.req_ready  = ready_c;
   assign bus.fifo_wr_en = accept;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = busy_q;

`ifdef FIFO_ARB_SRC_ID_EN
   assign bus.fifo_wr_data = {grant_q, own_data};
`else
   assign bus.fifo_wr_data = own_data;
`endif

   // Grant FSM: issue a grant from IDLE, release it after the accepted last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         grant_q <= '0;
         rr_ptr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found && !bus.fifo_almost_full) begin
                  state   <= GRANT;
                  busy_q  <= 1'b1;
                  grant_q <= pick_idx;
               end
            end
            GRANT: begin
               if (accept && own_last) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  rr_ptr <= (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Directed scenarios followed by randomized packets checked against a
// transaction-level round-robin model. Honours FIFO_ARB_SRC_ID_EN.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 8;
   localparam int unsigned IDW = 2;
`ifdef FIFO_ARB_SRC_ID_EN
   localparam int unsigned FWW = DW + IDW;
`else
   localparam int unsigned FWW = DW;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FWW-1:0] exp_word(input int unsigned id, input logic [7:0] d);
      logic [FWW-1:0] w;
`ifdef FIFO_ARB_SRC_ID_EN
      w = {IDW'(id), d};
`else
      w = d;
      if (id > NR) w = '0;
`endif
      return w;
   endfunction

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic full, input logic af);
      bus.req_valid        = v;
      bus.req_last         = l;
      bus.req_data         = d;
      bus.fifo_full        = full;
      bus.fifo_almost_full = af;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, '0, '0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic expect_state(input string tag, input logic b, input logic [3:0] rdy,
                               input logic wen);
      chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
      chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(wen));
   endtask

   task automatic expect_write(input string tag, input int unsigned id, input logic [7:0] d);
      chk({tag, ".gid"}, 32'(bus.grant_id), id);
      chk({tag, ".data"}, 32'(bus.fifo_wr_data), 32'(exp_word(id, d)));
   endtask

   beat_t            rq[NR][$];
   int               plen[NR][$];
   logic [FWW-1:0]   exp_q[$];

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      drive('0, '0, '0, 1'b0, 1'b0);

      // Reset state
      do_reset();
      mid();
      expect_state("reset", 1'b0, 4'b0000, 1'b0);
      chk("reset.gid", 32'(bus.grant_id), 0);

      // Req 1 and 3 valid, pointer at 0: 1 first, then 3
      tick();
      drive(4'b1010, 4'b1010, 32'h3300_1100, 1'b0, 1'b0);
      mid();
      expect_state("t30.idle0", 1'b0, 4'b0000, 1'b0);
      tick();
      mid();
      expect_state("t30.g1", 1'b1, 4'b0010, 1'b1);
      expect_write("t30.g1", 1, 8'h11);
      tick();
      drive(4'b1000, 4'b1000, 32'h3300_1100, 1'b0, 1'b0);
      mid();
      expect_state("t30.idle1", 1'b0, 4'b0000, 1'b0);
      tick();
      mid();
      expect_state("t30.g3", 1'b1, 4'b1000, 1'b1);
      expect_write("t30.g3", 3, 8'h33);
      tick();
      drive('0, '0, '0, 1'b0, 1'b0);
      mid();
      expect_state("t30.end", 1'b0, 4'b0000, 1'b0);

      // All four continuously valid, single-beat packets: 0,1,2,3,0 with bubbles
      do_reset();
      drive(4'hF, 4'hF, 32'h4342_4140, 1'b0, 1'b0);
      for (int r = 0; r < 5; r++) begin
         mid();
         expect_state($sformatf("t31.idle%0d", r), 1'b0, 4'b0000, 1'b0);
         tick();
         mid();
         expect_state($sformatf("t31.g%0d", r), 1'b1, 4'(1 << (r % 4)), 1'b1);
         expect_write($sformatf("t31.g%0d", r), r % 4, 8'(8'h40 + r % 4));
         tick();
      end
      drive('0, '0, '0, 1'b0, 1'b0);

      // fifo_full for 3 cycles in the middle of a 4-beat packet from req 2
      do_reset();
      drive(4'b0100, 4'b0000, 32'h00A0_0000, 1'b0, 1'b0);
      mid();
      expect_state("t32.idle", 1'b0, 4'b0000, 1'b0);
      tick();
      mid();
      expect_state("t32.b0", 1'b1, 4'b0100, 1'b1);
      expect_write("t32.b0", 2, 8'hA0);
      tick();
      drive(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 1'b0);
      mid();
      expect_state("t32.b1", 1'b1, 4'b0100, 1'b1);
      expect_write("t32.b1", 2, 8'hA1);
      for (int s = 0; s < 3; s++) begin
         tick();
         drive(4'b0100, 4'b0000, 32'h00A2_0000, 1'b1, 1'b0);
         mid();
         expect_state($sformatf("t32.stall%0d", s), 1'b1, 4'b0000, 1'b0);
         chk($sformatf("t32.stall%0d.gid", s), 32'(bus.grant_id), 2);
      end
      tick();
      drive(4'b0100, 4'b0000, 32'h00A2_0000, 1'b0, 1'b0);
      mid();
      expect_state("t32.b2", 1'b1, 4'b0100, 1'b1);
      expect_write("t32.b2", 2, 8'hA2);
      tick();
      drive(4'b0100, 4'b0100, 32'h00A3_0000, 1'b0, 1'b0);
      mid();
      expect_state("t32.b3", 1'b1, 4'b0100, 1'b1);
      expect_write("t32.b3", 2, 8'hA3);
      tick();
      drive('0, '0, '0, 1'b0, 1'b0);
      mid();
      expect_state("t32.end", 1'b0, 4'b0000, 1'b0);

      // almost_full holds off a grant in IDLE; GRANT ignores it
      do_reset();
      drive(4'b0001, 4'b0001, 32'h0000_005C, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         mid();
         expect_state($sformatf("t33.af%0d", s), 1'b0, 4'b0000, 1'b0);
         tick();
      end
      drive(4'b0001, 4'b0001, 32'h0000_005C, 1'b0, 1'b0);
      mid();
      expect_state("t33.drop", 1'b0, 4'b0000, 1'b0);
      tick();
      drive(4'b0001, 4'b0001, 32'h0000_005C, 1'b0, 1'b1);
      mid();
      expect_state("t33.g0", 1'b1, 4'b0001, 1'b1);
      expect_write("t33.g0", 0, 8'h5C);
      tick();
      drive('0, '0, '0, 1'b0, 1'b0);
      mid();
      expect_state("t33.end", 1'b0, 4'b0000, 1'b0);

      // Reset on the 2nd beat of a 4-beat packet from req 3 (pointer moved to 2 first)
      do_reset();
      drive(4'b0010, 4'b0010, 32'h0000_1100, 1'b0, 1'b0);
      tick();
      mid();
      expect_write("t34.pre", 1, 8'h11);
      tick();
      drive(4'b1000, 4'b0000, 32'hD000_0000, 1'b0, 1'b0);
      tick();
      mid();
      expect_state("t34.b0", 1'b1, 4'b1000, 1'b1);
      expect_write("t34.b0", 3, 8'hD0);
      tick();
      drive(4'b1000, 4'b0000, 32'hD100_0000, 1'b0, 1'b0);
      rst = 1'b1;
      mid();
      chk("t34.rst.ready", 32'(bus.req_ready), 0);
      chk("t34.rst.wr_en", 32'(bus.fifo_wr_en), 0);
      tick();
      rst = 1'b0;
      drive(4'b1010, 4'b1010, 32'h3300_1100, 1'b0, 1'b0);
      mid();
      expect_state("t34.after", 1'b0, 4'b0000, 1'b0);
      tick();
      mid();
      expect_state("t34.ptr0", 1'b1, 4'b0010, 1'b1);
      expect_write("t34.ptr0", 1, 8'h11);
      tick();
      drive('0, '0, '0, 1'b0, 1'b0);

`ifdef FIFO_ARB_SRC_ID_EN
      // Source ID prefix on the written word
      do_reset();
      drive(4'b0100, 4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
      tick();
      mid();
      chk("t35.word", 32'(bus.fifo_wr_data), 32'h0000_02A5);
      tick();
      drive('0, '0, '0, 1'b0, 1'b0);
`endif

      // Randomized packets against a packet-level round-robin model
      begin
         int          pidx[NR];
         int          boff[NR];
         int          ptr;
         bit          more;
         bit          in_pkt[NR];
         bit          done;
         int          cyc;
         logic [3:0]  v, l, acc;
         logic [31:0] d;
         beat_t       b;

         for (int k = 0; k < int'(NR); k++) begin
            int np;
            np = int'($urandom_range(1, 3));
            for (int p = 0; p < np; p++) begin
               int len;
               len = int'($urandom_range(1, 4));
               plen[k].push_back(len);
               for (int j = 0; j < len; j++) begin
                  b.d = 8'($urandom);
                  b.l = (j == len - 1);
                  rq[k].push_back(b);
               end
            end
            pidx[k]   = 0;
            boff[k]   = 0;
            in_pkt[k] = 1'b0;
         end

         ptr  = 0;
         more = 1'b1;
         while (more) begin
            more = 1'b0;
            for (int s = 0; s < int'(NR); s++) begin
               int k;
               k = (ptr + s) % int'(NR);
               if (!more && pidx[k] < plen[k].size()) begin
                  for (int j = 0; j < plen[k][pidx[k]]; j++)
                     exp_q.push_back(exp_word(k, rq[k][boff[k] + j].d));
                  boff[k] += plen[k][pidx[k]];
                  pidx[k]++;
                  ptr  = (k + 1) % int'(NR);
                  more = 1'b1;
               end
            end
         end

         do_reset();
         done = 1'b0;
         cyc  = 0;
         while (!done && cyc < 4000) begin
            v = '0;
            l = '0;
            d = '0;
            for (int k = 0; k < int'(NR); k++) begin
               if (rq[k].size() > 0) begin
                  v[k] = in_pkt[k] ? ($urandom_range(0, 3) != 0) : 1'b1;
                  l[k] = rq[k][0].l;
                  d[k*8 +: 8] = rq[k][0].d;
               end
            end
            drive(v, l, d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            mid();
            acc = bus.req_ready & v;
            chk("rnd.onehot", 32'($countones(bus.req_ready) <= 1), 1);
            chk("rnd.wr_en", 32'(bus.fifo_wr_en), 32'(|acc));
            if (bus.fifo_full) chk("rnd.full_ready", 32'(bus.req_ready), 0);
            if (bus.fifo_wr_en) begin
               if (exp_q.size() == 0) chk("rnd.extra_write", 1, 0);
               else chk("rnd.data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
            end
            tick();
            for (int k = 0; k < int'(NR); k++) begin
               if (acc[k]) begin
                  b         = rq[k].pop_front();
                  in_pkt[k] = !b.l;
               end
            end
            cyc++;
            done = (exp_q.size() == 0);
            for (int k = 0; k < int'(NR); k++)
               if (rq[k].size() != 0) done = 1'b0;
         end
         chk("rnd.drained", 32'(done), 1);
         chk("rnd.left", 32'(exp_q.size()), 0);
         drive('0, '0, '0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
